// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the decode front end and the immediate generator.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32/RV64 immediate generator with a main output register and a
// one-entry skid register. in_ready depends only on the skid occupancy, so
// upstream never sees a combinational path from out_ready.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  logic [31:0]      ins;
  logic [2:0]       dec_fmt;
  logic [31:0]      imm32;
  logic [XLEN-1:0]  dec_imm;

  logic             main_valid, skid_valid;
  logic [XLEN-1:0]  main_imm, skid_imm;
  logic [2:0]       main_fmt, skid_fmt;
  logic [TAG_W-1:0] main_tag, skid_tag;

  logic accept, consume, move_skid, load_main, load_skid;

  assign ins = bus.in_instr;

  // Opcode to format class; any opcode not ending in 2'b11 falls to illegal.
  always_comb begin
    dec_fmt = FMT_ILL;
    case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: dec_fmt = FMT_I;
      7'b0011011: dec_fmt = (XLEN == 64) ? FMT_I : FMT_ILL;
      7'b0100011: dec_fmt = FMT_S;
      7'b1100011: dec_fmt = FMT_B;
      7'b0110111, 7'b0010111: dec_fmt = FMT_U;
      7'b1101111: dec_fmt = FMT_J;
      7'b1110011: dec_fmt = ins[14] ? FMT_Z : FMT_I;
      7'b0110011: dec_fmt = FMT_R;
      7'b0111011: dec_fmt = (XLEN == 64) ? FMT_R : FMT_ILL;
      default:    dec_fmt = FMT_ILL;
    endcase
  end

  // Build a canonical 32-bit immediate; every format's value fits in 32 bits
  // signed, so a final sign-extending cast covers both XLEN settings (Z is
  // positive, so sign extension equals zero extension there).
  always_comb begin
    imm32 = 32'd0;
    case (dec_fmt)
      FMT_I: imm32 = {{20{ins[31]}}, ins[31:20]};
      FMT_S: imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B: imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U: imm32 = {ins[31:12], 12'd0};
      FMT_J: imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      FMT_Z: imm32 = {27'd0, ins[19:15]};
      default: imm32 = 32'd0;
    endcase
    dec_imm = XLEN'($signed(imm32));
  end

  assign accept    = bus.in_valid & ~skid_valid;
  assign consume   = main_valid & bus.out_ready;
  assign move_skid = consume & skid_valid;
  assign load_main = accept & (~main_valid | consume);
  assign load_skid = accept & main_valid & ~consume;

  // Occupancy flags; flush empties both entries and overrides every other update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= move_skid | load_main | (main_valid & ~consume);
      skid_valid <= load_skid | (skid_valid & ~consume);
    end
  end

  // Entry payloads; main holds still while stalled so out_* stay stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_imm <= '0;
      main_fmt <= FMT_R;
      main_tag <= '0;
      skid_imm <= '0;
      skid_fmt <= FMT_R;
      skid_tag <= '0;
    end else if (!flush) begin
      if (move_skid) begin
        main_imm <= skid_imm;
        main_fmt <= skid_fmt;
        main_tag <= skid_tag;
      end else if (load_main) begin
        main_imm <= dec_imm;
        main_fmt <= dec_fmt;
        main_tag <= bus.in_tag;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_fmt <= dec_fmt;
        skid_tag <= bus.in_tag;
      end
    end
  end

  assign bus.in_ready    = ~skid_valid;
  assign bus.out_valid   = main_valid;
  assign bus.out_imm     = main_imm;
  assign bus.out_fmt     = main_fmt;
  assign bus.out_illegal = (main_fmt == FMT_ILL);
  assign bus.out_tag     = main_tag;

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV32/RV64 decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes the opcode into a format class. It produces the XLEN-wide sign/zero-extended immediate plus an illegal-opcode flag, one cycle later. A two-entry skid buffer keeps full throughput under back-pressure, and a flush input supports branch redirects.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 32, width of the sideband tag (normally the PC) carried alongside each instruction.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all buffered entries.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  generated immediate.
- out_fmt  out  3  format class: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm), 7 illegal.
- out_illegal  out  1  high when out_fmt==7.
- out_tag  out  TAG_W  tag of the output entry.

## Operation
- An entry is accepted when in_valid & in_ready. It is consumed when out_valid & out_ready.
- Format decode uses opcode in_instr[6:0]. If in_instr[1:0] != 2'b11, the format is illegal.
  - I: 0000011, 0010011, 1100111, 0001111. 0011011 is I when XLEN==64 and illegal when XLEN==32.
  - S: 0100011. B: 1100011. U: 0110111, 0010111. J: 1101111.
  - 1110011 is Z when funct3[2]==1, otherwise I.
  - R: 0110011, and 0111011 (XLEN==64 only; illegal for XLEN==32).
  - Every other opcode is illegal.
- Immediate construction; all signed formats sign-extend from instr[31] to XLEN:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}, sign-extended to XLEN when XLEN==64.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Z = zero-extended instr[19:15].
  - R and illegal produce 0.
- Storage is an output register (main) plus one skid register.
  - in_ready = ~skid_valid.
  - Accept with main empty, or main being consumed, and skid empty: the entry goes to main.
  - Accept while main is held (out_valid & ~out_ready): the entry goes to skid.
  - On consume, a skid entry, if present, moves to main and skid empties. A same-cycle accept is impossible in that case (in_ready was 0).
- flush:
  - Next edge: out_valid=0 and skid_valid=0.
  - Any same-cycle accepted instruction is dropped.
  - A same-cycle consume still counts as completed for downstream.
  - flush has priority over all other updates.
- out_* fields are stable while out_valid & ~out_ready.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - out_valid=0, skid_valid=0, so in_ready=1.
  - out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
  - Inputs are ignored while rst_n is low.
- Latency: an instruction accepted at edge N appears with out_valid=1 after edge N.
- Throughput: 1 instruction/cycle with out_ready held high.
- Skid behaviour: in_ready deasserts the cycle after a stall first fills skid, and reasserts the cycle after the next consume.
- No combinational path from in_* to out_*. The only combinational path into in_ready is from the skid state register.
- Reset asserted mid-stream: all entries are lost. No output glitches to out_valid=1.

## Test plan
- Reset then idle: hold rst_n=0 for 3 cycles, then release -> out_valid=0, in_ready=1, out_imm=0. Reset asserted asynchronously mid-stream clears out_valid the same cycle.
- Formats, XLEN=32, out_ready=1. For each, the result appears the next cycle with out_tag equal to the input tag:
  - 0xFFF00093 -> imm 0xFFFFFFFF, fmt 1.
  - 0xFE000EE3 -> imm 0xFFFFFFFC, fmt 3.
  - 0x123450B7 -> imm 0x12345000, fmt 4.
  - 0x300FD073 -> imm 0x0000001F, fmt 6.
- XLEN=64:
  - 0x800000B7 -> imm 0xFFFFFFFF80000000, fmt 4.
  - 0x0010009B -> fmt 1, imm 1.
  - Same word with XLEN=32 -> fmt 7, out_illegal=1, imm 0.
- Illegal: 0x00000000 and 0x0000007F -> out_illegal=1, fmt 7, imm 0.
- Back-pressure: stream 4 instructions with out_ready=0 from cycle 2. Then:
  - Exactly 2 are accepted and in_ready=0.
  - Raising out_ready drains them in order, one per cycle.
  - The remaining 2 then flow with no loss or duplication.
- Flush with skid full, plus a concurrent in_valid -> next cycle out_valid=0 and in_ready=1. The flushed and concurrent instructions never appear on the output.
